baud_rate_gen: RTL

//  Consumer of the divisor latches: reads divisor MS/LS bytes and generates the

---
 rtl/baud_rate_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/baud_rate_gen.sv
// UART baud timing generator: divides m_clk by the 16-bit divisor latch value to
// produce an oversample strobe, and by OVERSAMPLE more to produce the bit strobe.
module baud_rate_gen #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    localparam int PHASE_W   = $clog2(OVERSAMPLE)
) (
    input  logic               m_clk,
    input  logic               reset,
    input  logic [7:0]         divisor_2,
    input  logic [7:0]         divisor_1,
    input  logic               enable,
    input  logic               restart,
    output logic               baud_tick16,
    output logic               baud_tick,
    output logic [PHASE_W-1:0] tick_phase,
    output logic               running
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r,  state_s;
    logic [DIV_WIDTH-1:0] cnt_r,    cnt_s;
    logic [DIV_WIDTH-1:0] div_q_r,  div_q_s;
    logic [PHASE_W-1:0]   phase_r,  phase_s;
    logic                 tick16_r, tick16_s;
    logic                 tick_r,   tick_s;
    logic [DIV_WIDTH-1:0] div_in_s;
    logic                 div_zero_s;

    assign div_in_s   = {divisor_2, divisor_1};
    assign div_zero_s = (div_in_s == {DIV_WIDTH{1'b0}});

    // Next-state and strobe decode; RUN rules are evaluated in priority order.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        div_q_s  = div_q_r;
        phase_s  = phase_r;
        tick16_s = 1'b0;
        tick_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                div_q_s = div_in_s;
                phase_s = {PHASE_W{1'b0}};
                if (enable && !div_zero_s) begin
                    state_s = ST_RUN;
                    cnt_s   = div_in_s - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s   = {DIV_WIDTH{1'b0}};
                end
            end
            ST_RUN: begin
                if (!enable || div_zero_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = {DIV_WIDTH{1'b0}};
                    phase_s = {PHASE_W{1'b0}};
                    div_q_s = div_in_s;
                end else if (restart || (div_in_s != div_q_r)) begin
                    cnt_s   = div_in_s - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                    phase_s = {PHASE_W{1'b0}};
                    div_q_s = div_in_s;
                end else if (cnt_r == {DIV_WIDTH{1'b0}}) begin
                    // phase is PHASE_W wide, so the increment wraps OVERSAMPLE-1 to 0
                    tick16_s = 1'b1;
                    tick_s   = (phase_r == PHASE_W'(OVERSAMPLE - 1));
                    cnt_s    = div_q_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                    phase_s  = phase_r + {{(PHASE_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s    = cnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {DIV_WIDTH{1'b0}};
                phase_s = {PHASE_W{1'b0}};
                div_q_s = {DIV_WIDTH{1'b0}};
            end
        endcase
    end

    // State, counter and registered strobe outputs.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {DIV_WIDTH{1'b0}};
            div_q_r  <= {DIV_WIDTH{1'b0}};
            phase_r  <= {PHASE_W{1'b0}};
            tick16_r <= 1'b0;
            tick_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            div_q_r  <= div_q_s;
            phase_r  <= phase_s;
            tick16_r <= tick16_s;
            tick_r   <= tick_s;
        end
    end

    assign baud_tick16 = tick16_r;
    assign baud_tick   = tick_r;
    assign tick_phase  = phase_r;
    assign running     = (state_r == ST_RUN);

endmodule
